// File: rtl/au_arbiter.sv
// -----------------------------------------------------------------------------
// au_arbiter
//
// Shares one arithmetic unit (au) between two requesters:
//   port 0 = sequencer datapath, port 1 = host/debug.
// Round-robin grant, a single operation in flight, and the result/completion
// pulse returned only to the requester that owns the operation.
//
// Operation flow: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE  : grant (combinational one-cycle gntN), operands latched at the edge
//   ISSUE : au_start pulse
//   WAIT  : wait for au_done (optionally bounded by a watchdog)
//   RESP  : doneN pulse to the owner, res valid
//
// Optional feature macro: AU_ARB_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent in WAIT. If TMO_CYC cycles
//   pass without au_done the operation is aborted: RESP with res=0, err=1.
//   When undefined, WAIT lasts until au_done and err is tied low.
//
// Parameters
//   W        operand/result width (format-agnostic)
//   TMO_CYC  watchdog limit in WAIT cycles (timeout build only)
//   TMOW     watchdog counter width, 2**TMOW must exceed TMO_CYC
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   req0/req1             level requests, held until the matching grant
//   op0/op1, r0/r1, s0/s1 operation and operands, sampled at grant
//   gnt0/gnt1             one-cycle grant pulse (cycle operands are captured)
//   done0/done1           one-cycle completion pulse to the owner
//   res                   result of last completed op, held until next one
//   err                   high with doneN when the watchdog aborted the op
//   busy                  high in any state other than IDLE
//   owner                 requester of the op in flight / last op
//   au_start              one-cycle start pulse to the au
//   au_op, au_r, au_s     latched op/operands to the au
//   au_result, au_done    au result and completion pulse
// -----------------------------------------------------------------------------
module au_arbiter #(
  parameter int W       = 24,
  parameter int TMO_CYC = 64,
  parameter int TMOW    = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [W-1:0] r0,
  input  logic [W-1:0] r1,
  input  logic [W-1:0] s0,
  input  logic [W-1:0] s1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res,
  output logic         err,
  output logic         busy,
  output logic         owner,
  output logic         au_start,
  output logic [1:0]   au_op,
  output logic [W-1:0] au_r,
  output logic [W-1:0] au_s,
  input  logic [W-1:0] au_result,
  input  logic         au_done
);

  // Elaboration-time guard on the watchdog counter width.
  if ((2 ** TMOW) <= TMO_CYC) begin : g_tmow_check
    $error("au_arbiter: TMOW too narrow for TMO_CYC");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t       state_q;
  logic         pref_q;      // 1: port 1 wins a tie, 0: port 0 wins a tie
  logic         owner_q;
  logic [W-1:0] res_q;
  logic         au_start_q;
  logic         done0_q;
  logic         done1_q;
  logic [1:0]   au_op_q;
  logic [W-1:0] au_r_q;
  logic [W-1:0] au_s_q;

`ifdef AU_ARB_TIMEOUT_EN
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TMO_CYC - 1);
  logic [TMOW-1:0] wdog_q;
  logic            err_q;
`endif

  // Grant decision. Gated with rst_n so every output is low while reset is
  // asserted, even though requests may already be high.
  logic         idle_ok;
  logic         pick1;
  logic [1:0]   op_d;
  logic [W-1:0] r_d;
  logic [W-1:0] s_d;

  assign idle_ok = rst_n && (state_q == ST_IDLE);
  assign pick1   = req1 && (!req0 || pref_q);
  assign gnt1    = idle_ok && pick1;
  assign gnt0    = idle_ok && req0 && !pick1;

  assign op_d = pick1 ? op1 : op0;
  assign r_d  = pick1 ? r1  : r0;
  assign s_d  = pick1 ? s1  : s0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pref_q     <= 1'b0;
      owner_q    <= 1'b0;
      res_q      <= '0;
      au_start_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      au_op_q    <= 2'b00;
      au_r_q     <= '0;
      au_s_q     <= '0;
`ifdef AU_ARB_TIMEOUT_EN
      wdog_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      au_start_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            owner_q    <= gnt1;
            pref_q     <= gnt0;   // the port not just served gets priority
            au_op_q    <= op_d;
            au_r_q     <= r_d;
            au_s_q     <= s_d;
            au_start_q <= 1'b1;
`ifdef AU_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // au_done here is ignored: the au cannot finish in zero cycles.
`ifdef AU_ARB_TIMEOUT_EN
          wdog_q  <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (au_done) begin
            // A completion in the expiry cycle still counts as normal.
            res_q   <= au_result;
            done0_q <= !owner_q;
            done1_q <= owner_q;
            state_q <= ST_RESP;
          end
`ifdef AU_ARB_TIMEOUT_EN
          else if (wdog_q == TMO_LAST) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            done0_q <= !owner_q;
            done1_q <= owner_q;
            state_q <= ST_RESP;
          end else begin
            wdog_q  <= wdog_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res      = res_q;
  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;
  assign au_start = au_start_q;
  assign au_op    = au_op_q;
  assign au_r     = au_r_q;
  assign au_s     = au_s_q;

`ifdef AU_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
